// File: rtl/dac_spi_scheduler_pkg.sv
// Shared definitions for the quad MEMS DAC SPI scheduler.
//   - DAC command codes and channel addresses
//   - scheduler state encoding
//   - make_dac_word(): packs {2'b00, cmd, addr, code} into a 24-bit DAC frame
package dac_spi_pkg;
  localparam int NUM_CH = 4;
  localparam int CODE_W = 16;
  localparam int WORD_W = 24;

  localparam logic [2:0] CMD_WRITE_UPDATE = 3'b011;
  localparam logic [2:0] CMD_SW_RESET     = 3'b101;
  localparam logic [2:0] CMD_LDAC         = 3'b110;

  localparam logic [2:0] CH_A = 3'd0;
  localparam logic [2:0] CH_B = 3'd1;
  localparam logic [2:0] CH_C = 3'd2;
  localparam logic [2:0] CH_D = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT0, ST_INIT1, ST_ARB, ST_XFER, ST_GAP, ST_ERROR
  } state_e;

  function automatic logic [WORD_W-1:0] make_dac_word(input logic [2:0] cmd,
                                                      input logic [2:0] addr,
                                                      input logic [CODE_W-1:0] code);
    return {2'b00, cmd, addr, code};
  endfunction
endpackage

// File: rtl/dac_spi_scheduler_if.sv
// Requester + SPI master bundle of the DAC scheduler.
//   master : scheduler side (drives acks and the SPI start/data)
//   slave  : requesters / SPI master side
//   req_valid/req_code/req_ack : per-channel request handshake, channel i at bit i / code [16i+15:16i]
//   spi_start/spi_data/spi_done: frame launch, 24-bit word, frame-finished pulse
interface dac_spi_scheduler_if;
  import dac_spi_pkg::*;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*CODE_W-1:0] req_code;
  logic [NUM_CH-1:0]        req_ack;
  logic                     spi_start;
  logic [WORD_W-1:0]        spi_data;
  logic                     spi_done;

  modport master (input req_valid, req_code, spi_done, output req_ack, spi_start, spi_data);
  modport slave  (output req_valid, req_code, spi_done, input req_ack, spi_start, spi_data);
endinterface

// File: rtl/dac_spi_scheduler_rr.sv
// Four-way round-robin arbiter.
//   valid : request vector, bit0 = A
//   en    : a grant is being taken this cycle; pointer moves past the winner
//   any   : at least one request
//   grant : first valid index at or after the pointer, wrapping D->A
//   ptr_q : current round-robin pointer
module rr_arbiter4
  import dac_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] valid,
  input  logic              en,
  output logic              any,
  output logic [1:0]        grant,
  output logic [1:0]        ptr_q
);
  logic [1:0] ptr_d;
  logic [1:0] idx;

  always_comb begin
    any   = |valid;
    grant = ptr_q;
    idx   = '0;
    // Walk offsets from far to near so the closest valid index wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (valid[idx]) grant = idx;
    end
    ptr_d = (en && any) ? grant + 2'd1 : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/dac_spi_scheduler.sv
// Owns the single SPI master for the quad 16-bit DAC: power-up init (software reset,
// LDAC setup), round-robin sharing among four requesters, inter-frame gap pacing and
// a watchdog on each frame.
//   clk, rst    : clock, synchronous active-high reset
//   init_start  : pulse, (re)run init; clears err
//   bus         : requester handshake and SPI start/data/done
//   init_done   : set when the LDAC-setup frame completes
//   busy        : high except in IDLE and in ARB with no request
//   err         : sticky watchdog expiry
module dac_spi_scheduler
  import dac_spi_pkg::*;
#(
  parameter bit                AUTO_INIT      = 1'b1,
  parameter logic [WORD_W-1:0] INIT_WORD0     = 24'h280001,
  parameter logic [WORD_W-1:0] INIT_WORD1     = 24'h30000F,
  parameter int unsigned       GAP_CYCLES     = 4,
  parameter int unsigned       TIMEOUT_CYCLES = 4096
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                init_start,
  dac_spi_scheduler_if.master bus,
  output logic                init_done,
  output logic                busy,
  output logic                err
);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_e              state_q, state_d, nxt;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                ret_arb_q, ret_arb_d;  // after the gap: 1 = ARB, 0 = INIT1
  logic                pend_q, pend_d;        // init_start seen mid-frame, not yet taken
  logic                init_done_q, init_done_d, err_q, err_d;
  logic                start_q, start_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                take, arb_en, arb_any, ret_now;
  logic [1:0]          grant, rr_ptr;
  state_e              post_st;

  rr_arbiter4 u_arb (
    .clk(clk), .rst(rst), .valid(bus.req_valid), .en(arb_en),
    .any(arb_any), .grant(grant), .ptr_q(rr_ptr)
  );

  // Where a finished frame (or an expired gap) leads; a pending init restart wins.
  assign ret_now = (state_q == ST_GAP) ? ret_arb_q : (state_q != ST_INIT0);
  assign post_st = (pend_q || init_start) ? ST_INIT0 : (ret_now ? ST_ARB : ST_INIT1);

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    ret_arb_d   = ret_arb_q;
    pend_d      = pend_q | init_start;
    init_done_d = init_done_q & ~init_start;
    err_d       = err_q;
    start_d     = 1'b0;
    ack_d       = '0;
    data_d      = data_q;
    arb_en      = 1'b0;
    take        = 1'b0;
    nxt         = ST_ARB;

    case (state_q)
      ST_IDLE: if (AUTO_INIT || init_start) begin take = 1'b1; nxt = ST_INIT0; end
      ST_INIT0, ST_INIT1, ST_XFER: begin
        if (bus.spi_done) begin
          ret_arb_d = ret_now;
          if (state_q == ST_INIT1 && !(pend_q || init_start)) init_done_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            take = 1'b1;
            nxt  = post_st;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end else if (wd_q >= WD_W'(TIMEOUT_CYCLES - 1)) begin
          // done arriving in this same cycle was taken above as success
          state_d     = ST_ERROR;
          err_d       = 1'b1;
          init_done_d = 1'b0;
        end else begin
          wd_d = (&wd_q) ? wd_q : wd_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q >= GAP_W'(GAP_CYCLES - 1)) begin
          take = 1'b1;
          nxt  = post_st;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_ARB: begin
        if (pend_q || init_start) begin
          take = 1'b1;
          nxt  = ST_INIT0;
        end else if (arb_any) begin
          arb_en       = 1'b1;
          start_d      = 1'b1;
          ack_d[grant] = 1'b1;
          data_d       = make_dac_word(CMD_WRITE_UPDATE, {1'b0, grant},
                                       bus.req_code[{grant, 4'b0000} +: CODE_W]);
          wd_d         = '0;
          state_d      = ST_XFER;
        end
      end
      ST_ERROR: if (init_start) begin err_d = 1'b0; take = 1'b1; nxt = ST_INIT0; end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      case (nxt)
        ST_INIT0: begin
          start_d = 1'b1; data_d = INIT_WORD0; wd_d = '0; pend_d = 1'b0; state_d = ST_INIT0;
        end
        ST_INIT1: begin
          start_d = 1'b1; data_d = INIT_WORD1; wd_d = '0; state_d = ST_INIT1;
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wd_q        <= '0;
      gap_q       <= '0;
      ret_arb_q   <= 1'b0;
      pend_q      <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      ack_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      ret_arb_q   <= ret_arb_d;
      pend_q      <= pend_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      data_q      <= data_d;
    end
  end

  assign bus.spi_start = start_q;
  assign bus.spi_data  = data_q;
  assign bus.req_ack   = ack_q;
  assign init_done     = init_done_q;
  assign err           = err_q;
  assign busy          = !((state_q == ST_IDLE) || (state_q == ST_ARB && !arb_any));
endmodule

// File: tb/tb_dac_spi_scheduler.sv
module tb_dac_spi_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, rst_b, init_start_a, init_start_b;
  logic init_done_a, busy_a, err_a, init_done_b, busy_b, err_b;
  dac_spi_scheduler_if ifa();
  dac_spi_scheduler_if ifb();

  dac_spi_scheduler #(.AUTO_INIT(1'b1), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64)) u_dut_a (
    .clk(clk), .rst(rst_a), .init_start(init_start_a), .bus(ifa),
    .init_done(init_done_a), .busy(busy_a), .err(err_a));
  dac_spi_scheduler #(.AUTO_INIT(1'b1), .GAP_CYCLES(0), .TIMEOUT_CYCLES(4096)) u_dut_b (
    .clk(clk), .rst(rst_b), .init_start(init_start_b), .bus(ifb),
    .init_done(init_done_b), .busy(busy_b), .err(err_b));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI master models: spi_done exactly lat cycles after the spi_start cycle.
  int lat_a = 30, lat_b = 5;
  bit mute_a = 0, rand_lat_a = 0, inject_a = 0;
  initial begin : resp_a
    int cnt;
    cnt = 0;
    ifa.spi_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      ifa.spi_done = 1'b0;
      if (rst_a) cnt = 0;
      else if (ifa.spi_start) cnt = rand_lat_a ? int'($urandom_range(1, 20)) : lat_a;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !mute_a) ifa.spi_done = 1'b1;
      end
      if (inject_a) begin ifa.spi_done = 1'b1; inject_a = 0; end
    end
  end
  initial begin : resp_b
    int cnt;
    cnt = 0;
    ifb.spi_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      ifb.spi_done = 1'b0;
      if (rst_b) cnt = 0;
      else if (ifb.spi_start) cnt = lat_b;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) ifb.spi_done = 1'b1;
      end
    end
  end

  task automatic wait_start(input bit sel_b, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sel_b ? ifb.spi_start : ifa.spi_start) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_tests++; n_fail++;
      $display("FAIL wait_start: no spi_start within %0d cycles (dut %0d)", budget, sel_b);
    end
  endtask

  task automatic wait_done(input bit sel_b, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sel_b ? ifb.spi_done : ifa.spi_done) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_tests++; n_fail++;
      $display("FAIL wait_done: no spi_done within %0d cycles (dut %0d)", budget, sel_b);
    end
  endtask

  function automatic logic [23:0] word_of(input int ch, input logic [15:0] code);
    return 24'h180000 | (24'(ch) << 16) | 24'(code);
  endfunction

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  ack;
    logic [23:0] word;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int s, d, s2, n;
    logic [63:0] saved;
    logic [3:0] v;
    logic [23:0] expw;
    int rptr, frames, last_done, g;

    tbl[0] = '{4'b1111, 4'b0001, 24'h181234};
    tbl[1] = '{4'b1111, 4'b0010, 24'h195555};
    tbl[2] = '{4'b1111, 4'b0100, 24'h1AABCD};
    tbl[3] = '{4'b1111, 4'b1000, 24'h1BFFFF};
    tbl[4] = '{4'b1111, 4'b0001, 24'h181234};
    tbl[5] = '{4'b1001, 4'b1000, 24'h1BFFFF};
    tbl[6] = '{4'b0110, 4'b0010, 24'h195555};
    tbl[7] = '{4'b0011, 4'b0001, 24'h181234};
    tbl[8] = '{4'b0100, 4'b0100, 24'h1AABCD};

    rst_a = 1; rst_b = 1; init_start_a = 0; init_start_b = 0;
    ifa.req_valid = '0; ifa.req_code = '0; ifb.req_valid = '0; ifb.req_code = '0;
    repeat (3) @(negedge clk);
    chk("rst_start", ifa.spi_start, 0);
    chk("rst_ack", ifa.req_ack, 0);
    chk("rst_data", ifa.spi_data, 0);
    chk("rst_flags", {init_done_a, busy_a, err_a}, 0);

    // Power-up init with a 30-cycle SPI master.
    rst_a = 0;
    wait_start(0, 10, s);
    chk("init0_word", ifa.spi_data, 24'h280001);
    chk("init0_ack", ifa.req_ack, 0);
    chk("init_busy", busy_a, 1);
    wait_done(0, 40, d);
    chk("init0_lat", d - s, 30);
    chk("init_done_early", init_done_a, 0);
    wait_start(0, 20, s2);
    chk("init1_word", ifa.spi_data, 24'h30000F);
    chk("init_gap", s2 - d - 1, 4);
    wait_done(0, 40, d);
    @(negedge clk);
    chk("init_done", init_done_a, 1);

    // Round-robin grant table; code changes after grant must not reach the frame.
    ifa.req_code = {16'hFFFF, 16'hABCD, 16'h5555, 16'h1234};
    for (int i = 0; i < 9; i++) begin
      ifa.req_valid = tbl[i].valid;
      wait_start(0, 100, s);
      chk($sformatf("tbl%0d_ack", i), ifa.req_ack, tbl[i].ack);
      chk($sformatf("tbl%0d_word", i), ifa.spi_data, tbl[i].word);
      saved = ifa.req_code;
      ifa.req_code = ~saved;
      wait_done(0, 100, d);
      chk($sformatf("tbl%0d_hold", i), ifa.spi_data, tbl[i].word);
      ifa.req_code = saved;
    end
    ifa.req_valid = '0;
    repeat (8) @(negedge clk);
    chk("arb_idle_busy", busy_a, 0);

    // init_start mid-frame with B waiting: frame completes, init re-runs, then B.
    ifa.req_valid = 4'b0010;
    wait_start(0, 20, s);
    chk("t5_b_ack", ifa.req_ack, 4'b0010);
    repeat (3) @(negedge clk);
    init_start_a = 1; @(negedge clk); init_start_a = 0;
    chk("t5_init_done_clr", init_done_a, 0);
    wait_done(0, 40, d);
    wait_start(0, 20, s);
    chk("t5_reinit0", ifa.spi_data, 24'h280001);
    chk("t5_reinit0_ack", ifa.req_ack, 0);
    wait_done(0, 40, d);
    wait_start(0, 20, s);
    chk("t5_reinit1", ifa.spi_data, 24'h30000F);
    chk("t5_reinit1_ack", ifa.req_ack, 0);
    wait_done(0, 40, d);
    wait_start(0, 20, s);
    chk("t5_b_after", ifa.req_ack, 4'b0010);
    chk("t5_b_word", ifa.spi_data, 24'h195555);
    chk("t5_init_done", init_done_a, 1);
    ifa.req_valid = '0;
    wait_done(0, 40, d);

    // Watchdog: SPI master never answers.
    mute_a = 1;
    ifa.req_valid = 4'b0100;
    wait_start(0, 20, s);
    chk("t4_c_ack", ifa.req_ack, 4'b0100);
    ifa.req_valid = '0;
    repeat (63) @(negedge clk);
    chk("t4_err_before", err_a, 0);
    @(negedge clk);
    chk("t4_err_at_64", err_a, 1);
    chk("t4_init_done", init_done_a, 0);
    n = 0;
    repeat (20) begin @(negedge clk); if (ifa.spi_start) n++; end
    chk("t4_no_start", n, 0);
    chk("t4_err_sticky", err_a, 1);
    mute_a = 0;
    init_start_a = 1; @(negedge clk); init_start_a = 0;
    chk("t4_err_clr", err_a, 0);
    chk("t4_restart", ifa.spi_start, 1);
    chk("t4_restart_word", ifa.spi_data, 24'h280001);
    wait_done(0, 40, d);
    wait_start(0, 20, s);
    wait_done(0, 40, d);
    @(negedge clk);
    chk("t4_init_done_again", init_done_a, 1);

    // Reset mid-frame, then a spurious spi_done while idle in ARB.
    ifa.req_valid = 4'b0001;
    wait_start(0, 20, s);
    ifa.req_valid = '0;
    repeat (5) @(negedge clk);
    rst_a = 1; @(negedge clk);
    chk("t6_rst_outs", {ifa.spi_start, ifa.req_ack, init_done_a, busy_a, err_a}, 0);
    chk("t6_rst_data", ifa.spi_data, 0);
    rst_a = 0;
    wait_start(0, 10, s);
    wait_done(0, 40, d);
    wait_start(0, 20, s);
    wait_done(0, 40, d);
    repeat (8) @(negedge clk);
    inject_a = 1;
    n = 0;
    repeat (10) begin @(negedge clk); if (ifa.spi_start || ifa.req_ack != 0) n++; end
    chk("t6_spurious_quiet", n, 0);
    chk("t6_spurious_busy", busy_a, 0);
    chk("t6_spurious_init_done", init_done_a, 1);
    ifa.req_valid = 4'b0001;
    wait_start(0, 20, s);
    chk("t6_alive", ifa.spi_data, 24'h181234);
    ifa.req_valid = '0;
    wait_done(0, 40, d);

    // Random requests against a grant/word reference model.
    rand_lat_a = 1;
    rptr = 1; v = '0; frames = 0; last_done = cyc - 100; expw = '0;
    for (int c = 0; c < 6000 && frames < 40; c++) begin
      @(negedge clk);
      if (ifa.spi_start) begin
        g = -1;
        for (int k = 0; k < 4; k++) if (g < 0 && v[(rptr + k) % 4]) g = (rptr + k) % 4;
        if (g < 0) begin
          n_tests++; n_fail++;
          $display("FAIL rnd_spurious_start: start with no request, data %0h", ifa.spi_data);
        end else begin
          expw = word_of(g, ifa.req_code[g*16 +: 16]);
          chk("rnd_ack", ifa.req_ack, 32'(1) << g);
          chk("rnd_word", ifa.spi_data, expw);
          chk("rnd_gap_min", (cyc - last_done) >= 6, 1);
          v[g] = 1'b0;
          rptr = (g + 1) % 4;
          frames++;
          ifa.req_code[g*16 +: 16] = 16'($urandom);
        end
      end
      if (ifa.spi_done) begin
        chk("rnd_hold", ifa.spi_data, expw);
        last_done = cyc;
      end
      for (int k = 0; k < 4; k++)
        if (!v[k] && $urandom_range(0, 7) == 0) begin
          v[k] = 1'b1;
          ifa.req_code[k*16 +: 16] = 16'($urandom);
        end
      ifa.req_valid = v;
    end
    chk("rnd_frames", frames, 40);

    // GAP_CYCLES=0 instance: lone channel C every slot, one idle clock between frames.
    rst_b = 0;
    wait_start(1, 10, s);
    chk("b_init0", ifb.spi_data, 24'h280001);
    wait_done(1, 20, d);
    wait_start(1, 10, s);
    chk("b_init1", ifb.spi_data, 24'h30000F);
    chk("b_init_gap", s - d, 1);
    wait_done(1, 20, d);
    @(negedge clk);
    chk("b_init_done", init_done_b, 1);
    ifb.req_code = {16'h0000, 16'hC0DE, 16'h0000, 16'h0000};
    ifb.req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      wait_start(1, 20, s);
      chk($sformatf("b_c_ack%0d", i), ifb.req_ack, 4'b0100);
      chk($sformatf("b_c_word%0d", i), ifb.spi_data, 24'h1AC0DE);
      if (i > 0) chk($sformatf("b_c_gap%0d", i), s - d, 2);
      wait_done(1, 20, d);
    end
    chk("b_ptr_d", u_dut_b.u_arb.ptr_q, 3);
    chk("b_no_err", {err_b, busy_b}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
